// File: rtl/mine_pkg.sv
// Shared definitions for the mine placement block and its neighbour counter.
// Contents: placer state enum, default board geometry and mine count, width of
// the adjacent-mine count (0..8 needs 4 bits).
package mine_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } state_e;

  localparam int unsigned DefRows  = 8;
  localparam int unsigned DefCols  = 8;
  localparam int unsigned DefMines = 10;
  localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/mine_nbr_count.sv
// Combinational 3x3 window popcount over a row-major ROWS x COLS mine bitmap.
// Neighbours that fall outside the board are masked; edges never wrap.
// Ports:
//   bitmap_i  - mine bitmap, bit (row*COLS + col)
//   row_i     - centre row
//   col_i     - centre column
//   cnt_o     - mines among the in-bounds 8-neighbours (centre excluded)
module mine_nbr_count import mine_pkg::*; #(
  parameter int unsigned ROWS = DefRows,
  parameter int unsigned COLS = DefCols
) (
  input  logic [ROWS*COLS-1:0]    bitmap_i,
  input  logic [$clog2(ROWS)-1:0] row_i,
  input  logic [$clog2(COLS)-1:0] col_i,
  output logic [CNT_W-1:0]        cnt_o
);

  localparam int unsigned IdxW = $clog2(ROWS * COLS);

  int              nr;
  int              nc;
  logic [IdxW-1:0] nidx;

  always_comb begin
    cnt_o = '0;
    nr    = 0;
    nc    = 0;
    nidx  = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr   = int'(row_i) + dr;
        nc   = int'(col_i) + dc;
        // Index may be garbage for off-board neighbours; the bounds test masks it.
        nidx = IdxW'(nr * int'(COLS) + nc);
        if (!(dr == 0 && dc == 0) && nr >= 0 && nr < int'(ROWS) &&
            nc >= 0 && nc < int'(COLS)) begin
          cnt_o = cnt_o + {{(CNT_W-1){1'b0}}, bitmap_i[nidx]};
        end
      end
    end
  end

endmodule

// File: rtl/mine_placer.sv
// Mine placer: consumes a random index stream, rejects out-of-range, duplicate
// and protected cells, and records accepted mines in a ROWS x COLS bitmap until
// MINES are placed (or STALL_MAX consecutive rejects abort the fill). A
// registered query port returns a cell's mine bit and adjacent-mine count.
// Optional feature macro: MINE_SAFE_ZONE_EN - protect the safe cell and its
// in-bounds 8-neighbours instead of the safe cell alone.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start_i                  - begin generation (ignored while filling)
//   safe_row_i, safe_col_i   - first-click cell, sampled on start
//   rnd_i                    - random cell index, one draw per cycle in fill
//   busy_o, done_o, err_o    - filling / map complete / stall abort
//   q_valid_i, q_row_i, q_col_i - query strobe and cell
//   r_valid_o, r_mine_o, r_cnt_o - registered query response
module mine_placer import mine_pkg::*; #(
  parameter  int unsigned ROWS      = DefRows,
  parameter  int unsigned COLS      = DefCols,
  parameter  int unsigned MINES     = DefMines,
  parameter  int unsigned STALL_MAX = 1023,
  localparam int unsigned IDX_W     = $clog2(ROWS * COLS),
  localparam int unsigned RW        = $clog2(ROWS),
  localparam int unsigned CW        = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [RW-1:0]    safe_row_i,
  input  logic [CW-1:0]    safe_col_i,
  input  logic [IDX_W-1:0] rnd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic             q_valid_i,
  input  logic [RW-1:0]    q_row_i,
  input  logic [CW-1:0]    q_col_i,
  output logic             r_valid_o,
  output logic             r_mine_o,
  output logic [CNT_W-1:0] r_cnt_o
);

  localparam int unsigned Cells = ROWS * COLS;
  localparam int unsigned McW   = $clog2(MINES + 1);
  localparam int unsigned StW   = $clog2(STALL_MAX + 1);

  state_e           state_q;
  logic [Cells-1:0] bitmap_q;
  logic [McW-1:0]   mine_cnt_q;
  logic [StW-1:0]   stall_q;
  logic [RW-1:0]    safe_row_q;
  logic [CW-1:0]    safe_col_q;

  logic in_range;
  logic is_free;
  logic is_prot;
  logic accept;

  // Extra bit keeps the compare correct when Cells is a power of two.
  assign in_range = ({1'b0, rnd_i} < (IDX_W + 1)'(Cells));
  // Out-of-range reads are don't-care; in_range masks them.
  assign is_free  = ~bitmap_q[rnd_i];

`ifdef MINE_SAFE_ZONE_EN
  logic [IDX_W-1:0] rnd_row;
  logic [IDX_W-1:0] rnd_col;
  int               drow;
  int               dcol;

  always_comb begin
    rnd_row = rnd_i / IDX_W'(COLS);
    rnd_col = rnd_i % IDX_W'(COLS);
    drow    = int'(rnd_row) - int'(safe_row_q);
    dcol    = int'(rnd_col) - int'(safe_col_q);
    is_prot = (drow >= -1) && (drow <= 1) && (dcol >= -1) && (dcol <= 1);
  end
`else
  assign is_prot = (rnd_i == IDX_W'(safe_row_q) * IDX_W'(COLS) + IDX_W'(safe_col_q));
`endif

  assign accept = in_range & is_free & ~is_prot;
  assign busy_o = (state_q == StFill);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bitmap_q   <= '0;
      mine_cnt_q <= '0;
      stall_q    <= '0;
      safe_row_q <= '0;
      safe_col_q <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            bitmap_q   <= '0;
            mine_cnt_q <= '0;
            stall_q    <= '0;
            safe_row_q <= safe_row_i;
            safe_col_q <= safe_col_i;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            state_q    <= StFill;
          end
        end
        StFill: begin
          if (accept) begin
            bitmap_q[rnd_i] <= 1'b1;
            mine_cnt_q      <= mine_cnt_q + McW'(1);
            stall_q         <= '0;
            if (mine_cnt_q == McW'(MINES - 1)) begin
              done_o  <= 1'b1;
              state_q <= StDone;
            end
          end else begin
            stall_q <= stall_q + StW'(1);
            // This reject is the STALL_MAX-th in a row: give up, keep partial map.
            if (stall_q == StW'(STALL_MAX - 1)) begin
              err_o   <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Query path: answers from the bitmap as it stands before this cycle's accept.
  logic [IDX_W-1:0] q_idx;
  logic             q_in;
  logic [CNT_W-1:0] nbr_cnt;

  assign q_idx = IDX_W'(q_row_i) * IDX_W'(COLS) + IDX_W'(q_col_i);
  assign q_in  = (int'(q_row_i) < int'(ROWS)) && (int'(q_col_i) < int'(COLS));

  mine_nbr_count #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_nbr (
    .bitmap_i (bitmap_q),
    .row_i    (q_row_i),
    .col_i    (q_col_i),
    .cnt_o    (nbr_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_o <= 1'b0;
      r_mine_o  <= 1'b0;
      r_cnt_o   <= '0;
    end else begin
      r_valid_o <= q_valid_i;
      if (q_valid_i) begin
        r_mine_o <= q_in & bitmap_q[q_idx];
        r_cnt_o  <= nbr_cnt;
      end
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer on a 9x9 board (7-bit index, so out-of-range draws occur),
// 10 mines, stall limit 15. A cell-array reference model runs in lock-step.
module tb_mine_placer;

  localparam int unsigned ROWS      = 9;
  localparam int unsigned COLS      = 9;
  localparam int unsigned MINES     = 10;
  localparam int unsigned STALL_MAX = 15;
  localparam int unsigned CELLS     = ROWS * COLS;
  localparam int unsigned IDX_W     = $clog2(CELLS);
  localparam int unsigned RW        = $clog2(ROWS);
  localparam int unsigned CW        = $clog2(COLS);

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [RW-1:0]    safe_row_i;
  logic [CW-1:0]    safe_col_i;
  logic [IDX_W-1:0] rnd_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic             q_valid_i;
  logic [RW-1:0]    q_row_i;
  logic [CW-1:0]    q_col_i;
  logic             r_valid_o;
  logic             r_mine_o;
  logic [3:0]       r_cnt_o;

  always #5 clk = ~clk;

  mine_placer #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .MINES     (MINES),
    .STALL_MAX (STALL_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .safe_row_i (safe_row_i),
    .safe_col_i (safe_col_i),
    .rnd_i      (rnd_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .q_valid_i  (q_valid_i),
    .q_row_i    (q_row_i),
    .q_col_i    (q_col_i),
    .r_valid_o  (r_valid_o),
    .r_mine_o   (r_mine_o),
    .r_cnt_o    (r_cnt_o)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  string phase    = "init";

  // Reference model: 0 idle, 1 fill, 2 done
  bit m_map [CELLS];
  int m_state;
  int m_cnt, m_stall, m_srow, m_scol;
  bit m_done, m_err, m_rv, m_rm;
  int m_rc;
  int seq_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s @cyc %0d: got %0d expected %0d", phase, tag, cyc, got, exp);
    end
  endtask

  function automatic bit prot(int idx);
    int r;
    int c;
    r = idx / COLS;
    c = idx % COLS;
`ifdef MINE_SAFE_ZONE_EN
    return (r >= m_srow - 1) && (r <= m_srow + 1) && (c >= m_scol - 1) && (c <= m_scol + 1);
`else
    return (r == m_srow) && (c == m_scol);
`endif
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Count mines at Chebyshev distance exactly 1 from (row, col).
  function automatic int nbr(int row, int col);
    int n;
    int r;
    int c;
    n = 0;
    for (int i = 0; i < CELLS; i++) begin
      r = i / COLS;
      c = i % COLS;
      if (m_map[i] && !(r == row && c == col) && iabs(r - row) <= 1 && iabs(c - col) <= 1)
        n++;
    end
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) m_map[i] = 1'b0;
    m_cnt   = 0;
    m_stall = 0;
    m_done  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic cycle(input bit st, input int sr, input int sc, input int rnd,
                       input bit qv, input int qr, input int qc);
    start_i    = st;
    safe_row_i = RW'(sr);
    safe_col_i = CW'(sc);
    rnd_i      = IDX_W'(rnd);
    q_valid_i  = qv;
    q_row_i    = RW'(qr);
    q_col_i    = CW'(qc);
    m_rv = qv;
    if (qv) begin
      m_rm = m_map[qr * COLS + qc];
      m_rc = nbr(qr, qc);
    end
    if (m_state != 1) begin
      if (st) begin
        model_clear();
        m_srow  = sr;
        m_scol  = sc;
        m_state = 1;
      end
    end else begin
      if (rnd < CELLS && !m_map[rnd] && !prot(rnd)) begin
        m_map[rnd] = 1'b1;
        m_cnt++;
        m_stall = 0;
        if (m_cnt == MINES) begin
          m_done  = 1'b1;
          m_state = 2;
        end
      end else begin
        m_stall++;
        if (m_stall == STALL_MAX) begin
          m_err   = 1'b1;
          m_state = 2;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_eq("busy", busy_o, m_state == 1);
    check_eq("done", done_o, m_done);
    check_eq("err", err_o, m_err);
    check_eq("r_valid", r_valid_o, m_rv);
    check_eq("r_mine", r_mine_o, m_rm);
    check_eq("r_cnt", r_cnt_o, m_rc);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    start_i   = 1'b0;
    q_valid_i = 1'b0;
    rnd_i     = '0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    model_clear();
    m_state = 0;
    m_rv    = 1'b0;
    m_rm    = 1'b0;
    m_rc    = 0;
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_rvalid", r_valid_o, 0);
    check_eq("rst_rmine", r_mine_o, 0);
    check_eq("rst_rcnt", r_cnt_o, 0);
  endtask

  // Start, then feed seq_q one draw per cycle; latencies counted in cycles from start.
  task automatic run_seq(input int sr, input int sc, output int lat_done, output int lat_err);
    int s;
    lat_done = -1;
    lat_err  = -1;
    cycle(1, sr, sc, 0, 0, 0, 0);
    s = cyc;
    foreach (seq_q[i]) begin
      cycle(0, sr, sc, seq_q[i], 0, 0, 0);
      if (done_o && lat_done < 0) lat_done = cyc - s + 1;
      if (err_o && lat_err < 0) lat_err = cyc - s + 1;
    end
  endtask

  task automatic query(input int r, input int c, input int rnd);
    cycle(0, 0, 0, rnd, 1, r, c);
  endtask

  task automatic sweep();
    for (int i = 0; i < CELLS; i++) query(i / COLS, i % COLS, 127);
  endtask

  int ld, le;

  initial begin
    rst        = 1'b1;
    start_i    = 1'b0;
    safe_row_i = '0;
    safe_col_i = '0;
    rnd_i      = '0;
    q_valid_i  = 1'b0;
    q_row_i    = '0;
    q_col_i    = '0;
    m_state = 0;
    m_srow  = 0;
    m_scol  = 0;
    m_rv = 0; m_rm = 0; m_rc = 0;
    model_clear();

    phase = "reset";
    do_reset();

`ifndef MINE_SAFE_ZONE_EN
    phase = "seq1";
    seq_q.delete();
    for (int k = 1; k <= 11; k++) seq_q.push_back(k);
    run_seq(0, 0, ld, le);
    check_eq("done_lat", ld, 11);
    query(0, 0, 0);
    check_eq("safe_mine", r_mine_o, 0);
`else
    phase = "zone";
    seq_q = '{30, 31, 32, 39, 40, 41, 48, 49, 50, 0};
    run_seq(4, 4, ld, le);
    query(0, 0, 127);
    check_eq("zone_mine0", r_mine_o, 1);
    query(4, 4, 127);
    check_eq("zone_cnt", r_cnt_o, 0);
`endif

    phase = "dup";
    do_reset();
    seq_q.delete();
    seq_q.push_back(3);
    seq_q.push_back(3);
    for (int k = 3; k <= 12; k++) seq_q.push_back(k);
    run_seq(8, 8, ld, le);
    check_eq("done_lat", ld, 13);

    phase = "range";
    do_reset();
    seq_q = '{100, 80};
    run_seq(0, 0, ld, le);
    query(8, 8, 127);
    check_eq("mine80", r_mine_o, 1);
    query(7, 7, 127);
    check_eq("cnt77", r_cnt_o, 1);

    phase = "stall";
    do_reset();
    seq_q.delete();
    seq_q.push_back(5);
    for (int k = 0; k < 20; k++) seq_q.push_back(0);
    run_seq(0, 0, ld, le);
    check_eq("err_lat", le, 17);
    check_eq("no_done", done_o, 0);

    phase = "nbr";
    do_reset();
    seq_q = '{1, 9, 10};
    run_seq(8, 8, ld, le);
    query(0, 0, 127);
    check_eq("m00", r_mine_o, 0);
    check_eq("c00", r_cnt_o, 3);
    query(8, 8, 127);
    check_eq("c88", r_cnt_o, 0);
    query(0, 1, 127);
    check_eq("m01", r_mine_o, 1);
    check_eq("c01", r_cnt_o, 2);
    cycle(0, 0, 0, 2, 1, 0, 1);          // accept of cell 2 in the same cycle
    check_eq("c01_same", r_cnt_o, 2);
    query(0, 1, 127);
    check_eq("c01_after", r_cnt_o, 3);
    cycle(1, 0, 0, 11, 0, 0, 0);         // start while filling is ignored
    cycle(0, 0, 0, 12, 0, 0, 0);

    phase = "rst_mid";
    do_reset();
    sweep();

    phase = "random";
    for (int run = 0; run < 16; run++) begin
      bit stall_mode;
      int sr;
      int sc;
      int rnd;
      stall_mode = (run % 4 == 3);
      if (run % 5 == 0) do_reset();
      sr = $urandom_range(0, ROWS - 1);
      sc = $urandom_range(0, COLS - 1);
      cycle(1, sr, sc, 0, 0, 0, 0);
      for (int k = 0; k < 120; k++) begin
        if (stall_mode && $urandom_range(0, 15) != 0) rnd = $urandom_range(CELLS, 127);
        else rnd = $urandom_range(0, 127);
        cycle(($urandom_range(0, 19) == 0), $urandom_range(0, ROWS - 1),
              $urandom_range(0, COLS - 1), rnd, $urandom_range(0, 1),
              $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
      end
      if (run % 4 == 0) sweep();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mine_placer.md
# mine_placer

Consumer of the LFSR random stream in the game core. On `start` it draws cell indices from `rnd_i` once per cycle, rejects out-of-range, duplicate and protected cells, and records accepted mines in an internal ROWS×COLS bitmap until MINES are placed. A registered query port then returns each cell's mine bit and adjacent-mine count to the render/reveal logic.

## Interface
- `ROWS`, 8, board rows (≥3)
- `COLS`, 8, board columns (≥3)
- `MINES`, 10, mines to place (1 ≤ MINES ≤ ROWS*COLS−9)
- `STALL_MAX`, 1023, consecutive rejected draws before abort
- `IDX_W`, derived = $clog2(ROWS*COLS), index/random width

- `clk` in 1 — clock; single clock domain
- `rst` in 1 — synchronous, active-high reset
- `start_i` in 1 — pulse; begin generation
- `safe_row_i` in $clog2(ROWS) — first-click row, sampled on start
- `safe_col_i` in $clog2(COLS) — first-click column, sampled on start
- `rnd_i` in IDX_W — random index, new value every cycle
- `busy_o` out 1 — placement in progress
- `done_o` out 1 — map complete, held until next start/reset
- `err_o` out 1 — stall abort, held until next start/reset
- `q_valid_i` in 1 — query strobe
- `q_row_i` in $clog2(ROWS); `q_col_i` in $clog2(COLS) — query cell
- `r_valid_o` out 1 — response valid
- `r_mine_o` out 1 — queried cell holds a mine
- `r_cnt_o` out 4 — mines in 8-neighbourhood (0–8)

## Operation
- States: IDLE, FILL, DONE. Reset → IDLE; bitmap, mine counter, stall counter, all outputs 0.
- IDLE/DONE + `start_i`: clear bitmap, counters, `done_o`, `err_o`; latch safe cell; → FILL.
- `start_i` in FILL ignored.
- FILL, each cycle, idx = `rnd_i`; accept iff idx < ROWS*COLS, bitmap[idx]==0, idx not protected. Row = idx / COLS, col = idx % COLS (row-major).
- Accept: bitmap[idx]←1, count+1, stall←0. When count reaches MINES → DONE, `done_o`←1.
- Reject: stall+1; at stall==STALL_MAX → DONE with `err_o`←1, `done_o`←0, partial map kept.
- `busy_o` = (state==FILL).
- Query: `r_cnt_o` sums in-bounds neighbours only; edges/corners never wrap. Query served in every state against current bitmap.

## Timing
- Start cycle N: FILL from N+1; first draw sampled N+1.
- Best case: MINES accepted in MINES consecutive cycles; `done_o` high MINES+1 cycles after start.
- Final accept on cycle M: `busy_o` low and `done_o` high at M+1.
- Query at cycle N → `r_valid_o`, `r_mine_o`, `r_cnt_o` registered at N+1; throughput one per cycle; `r_valid_o` low otherwise, other r_* hold.
- `rst` mid-FILL: next cycle IDLE, bitmap cleared, no done/err.
- Query and accept same cycle: response reflects bitmap before the accept.

## Configuration
- `MINE_SAFE_ZONE_EN` defined: protected set = safe cell plus its in-bounds 8-neighbours (first click always opens a zero).
- Undefined: protected set = safe cell only; MINES bound relaxes to ROWS*COLS−1.

## Structure
- Shared package `mine_pkg`: state enum (IDLE/FILL/DONE), default ROWS/COLS/MINES, `CNT_W`=4.
- Sub-module `mine_nbr_count`: combinational 3×3 window popcount with bounds masking, given bitmap and row/col; reused by reveal logic.

## Test plan
- 8×8, MINES=10, safe (0,0), rnd 5,5,70-out-of-range-n/a(use 9×9),… sequence 1,2,…,11 without macro → idx 1–10 placed, 0 never drawn, `done_o` at start+11.
- Duplicate: rnd 3,3,3,4 with MINES=2 → bitmap bits 3,4 only; done 5 cycles after start.
- 9×9 (IDX_W=7), rnd 100 then 80 → 100 rejected, 80 accepted.
- Macro on, safe (4,4) 8×8, rnd 27,28,29,35,36,37,43,44,45,0 → only 0 accepted.
- Constant rnd 0 after first accept, STALL_MAX=15 → `err_o` high 16 cycles after last accept, `done_o` 0.
- Mines at (0,1),(1,0),(1,1); query (0,0) → next cycle `r_mine_o`=0, `r_cnt_o`=3; query (7,7) → 0; `rst` mid-FILL → bitmap empty.
